maq_alarma_multicanal: RTL and testbench
========================================

MAQ_ALARMA_MULTICANAL -- requirements
Module: maq_alarma_multicanal

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of sensor channels, legal range 1..9.
REQ-002 SHALL have parameter DEB_CYC, default 16: persistence cycles for the per-channel filter, legal range 2..65535.
REQ-003 SHALL have port CLK_clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Sensor_i, input, N_CH bits: raw sensor levels, synchronous to CLK_clk_i; 1 means condition present.
REQ-006 SHALL have port Ack_i, input, 1 bit: operator acknowledge, sampled each cycle.
REQ-007 SHALL have port variableestado_o, output, 7 bits: state digit for an active-low 7-segment display, bit order gfedcba.
REQ-008 SHALL have port variablealerta_o, output, 7 bits: filtered-active channel count on the same display encoding.
REQ-009 SHALL have port Led_o, output, N_CH bits: latched per-channel indicators.
REQ-010 SHALL have port Alarma_o, output, 1 bit: buzzer drive.
REQ-011 SHALL have port Activos_o, output, $clog2(N_CH+1) bits: binary count of filtered-active channels.

Function
REQ-012 SHALL run one filter per channel i: a counter increments while Sensor_i[i] differs from filt[i] and clears to 0 when they match.
REQ-013 SHALL toggle filt[i] and clear the counter on the edge where the counter reaches DEB_CYC-1, so a change held for DEB_CYC consecutive edges propagates; any shorter pulse is discarded.
REQ-014 SHALL define c as the popcount of filt and r as 1 when any filt bit goes 0->1 on the current edge; Activos_o SHALL equal c.
REQ-015 SHALL implement 4 states with codes: REPOSO=0, ALERTA=1, ALARMA=2, RECONOCIDA=3.
REQ-016 SHALL apply these transitions from REPOSO: c==1 -> ALERTA; c>=2 -> ALARMA; otherwise stay.
REQ-017 SHALL apply these transitions from ALERTA, in priority order: c==0 -> REPOSO; c>=2 -> ALARMA; Ack_i && !r -> RECONOCIDA; otherwise stay.
REQ-018 SHALL apply these transitions from ALARMA, in priority order: c==0 -> REPOSO; Ack_i && !r -> RECONOCIDA; otherwise stay; it SHALL NOT fall back to ALERTA when c drops to 1.
REQ-019 SHALL apply these transitions from RECONOCIDA, in priority order: c==0 -> REPOSO; r -> ALARMA; otherwise stay.
REQ-020 SHALL evaluate transitions on registered filt, c and r, so the state changes one edge after the filt change.
REQ-021 SHALL set Led_o[i] on the edge where filt[i] rises; Led_o[i] SHALL clear only on an edge with Ack_i==1 and filt[i]==0, and SHALL stay set otherwise.
REQ-022 SHALL drive Alarma_o to 1 exactly while the state is ALARMA.
REQ-023 SHALL drive variableestado_o from the state code and variablealerta_o from c, using the following digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 SHALL produce all outputs by decoding registers only, with no combinational path from Sensor_i or Ack_i.
REQ-025 SHALL give a rise-versus-Ack_i collision in the same cycle to the rise: the state remains or becomes ALARMA, and the newly risen Led_o bit is set.
REQ-026 SHALL treat Ack_i in REPOSO as no effect on state; LEDs of inactive channels still clear per REQ-021.

Reset
REQ-027 SHALL, while RST_rst_n_i==0 and without waiting for a clock edge, force: state=REPOSO, filt=0, all filter counters=0, Led_o=0, Alarma_o=0, Activos_o=0, variableestado_o=1000000, variablealerta_o=1000000.
REQ-028 SHALL begin normal evaluation on the first rising edge after RST_rst_n_i deasserts; sensors already high at that point SHALL be filtered afresh (DEB_CYC edges).

Verification (N_CH=4, DEB_CYC=4)
REQ-029 SHALL cover reset: after reset, both displays = 1000000, Led_o=0000, Alarma_o=0, Activos_o=0.
REQ-030 SHALL cover glitch rejection: Sensor_i=0001 held for 3 edges then 0000 -> filt, state and all outputs unchanged.
REQ-031 SHALL cover single-channel alert: Sensor_i=0010 held for 6 edges -> state ALERTA, variableestado_o=1111001, variablealerta_o=1111001, Led_o=0010, Alarma_o=0.
REQ-032 SHALL cover escalation and acknowledge: add channel 2 (Sensor_i=0110) -> ALARMA, Alarma_o=1, both displays=0100100; a 1-cycle Ack_i pulse -> RECONOCIDA, variableestado_o=0110000, Alarma_o=0; then raise channel 3 -> ALARMA, Led_o=1110.
REQ-033 SHALL cover the collision case: Ack_i asserted on the same edge as a filt rise while in ALARMA -> state stays ALARMA and Alarma_o stays 1.
REQ-034 SHALL cover mid-operation reset: RST_rst_n_i driven low between clock edges while in ALARMA -> outputs match REQ-029 before the next edge; with sensors held high, ALARMA is re-entered DEB_CYC+1 edges after release.

Source files
------------

// File: rtl/maq_alarma_multicanal.sv
// Multichannel alarm controller: per-channel persistence filters feeding an
// alert/alarm/acknowledge FSM, with latched LEDs and 7-segment status digits.
//
// state      | meaning
// REPOSO     | no filtered channel active
// ALERTA     | exactly one channel active, not yet acknowledged
// ALARMA     | two or more channels seen, buzzer on
// RECONOCIDA | operator acknowledged, buzzer silenced
module maq_alarma_multicanal #(
  parameter int N_CH    = 4,
  parameter int DEB_CYC = 16
) (
  input  logic                        CLK_clk_i,
  input  logic                        RST_rst_n_i,
  input  logic [N_CH-1:0]             Sensor_i,
  input  logic                        Ack_i,
  output logic [6:0]                  variableestado_o,
  output logic [6:0]                  variablealerta_o,
  output logic [N_CH-1:0]             Led_o,
  output logic                        Alarma_o,
  output logic [$clog2(N_CH+1)-1:0]   Activos_o
);

  localparam int CW = $clog2(DEB_CYC);
  localparam int AW = $clog2(N_CH+1);
  localparam logic [CW-1:0] TC = CW'(DEB_CYC - 1);

  localparam logic [1:0] REPOSO     = 2'd0;
  localparam logic [1:0] ALERTA     = 2'd1;
  localparam logic [1:0] ALARMA     = 2'd2;
  localparam logic [1:0] RECONOCIDA = 2'd3;

  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] filt_q, filt_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] rise;
  logic            r_q, r_d;
  logic            ack_q, ack_d;
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (Sensor_i[i] != filt_q[i]) begin
        if (cnt_q[i] == TC) filt_d[i] = ~filt_q[i];
        else                cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise  = filt_d & ~filt_q;
    r_d   = |rise;
    ack_d = Ack_i;
    // A new rise wins over an acknowledge that would clear the same LED
    led_d = rise | (led_q & ~({N_CH{Ack_i}} & ~filt_q));
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + AW'(filt_q[i]);
  end

  // Ack is taken from the same registered view as r, so an acknowledge
  // arriving together with a filter rise is overridden by that rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REPOSO: begin
        if (c == AW'(1))      state_d = ALERTA;
        else if (c >= AW'(2)) state_d = ALARMA;
      end
      ALERTA: begin
        if (c == '0)              state_d = REPOSO;
        else if (c >= AW'(2))     state_d = ALARMA;
        else if (ack_q && !r_q)   state_d = RECONOCIDA;
      end
      ALARMA: begin
        if (c == '0)              state_d = REPOSO;
        else if (ack_q && !r_q)   state_d = RECONOCIDA;
      end
      default: begin
        if (c == '0)   state_d = REPOSO;
        else if (r_q)  state_d = ALARMA;
      end
    endcase
  end

  always_ff @(posedge CLK_clk_i or negedge RST_rst_n_i) begin
    if (!RST_rst_n_i) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      filt_q  <= '0;
      led_q   <= '0;
      r_q     <= 1'b0;
      ack_q   <= 1'b0;
      state_q <= REPOSO;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      filt_q  <= filt_d;
      led_q   <= led_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      state_q <= state_d;
    end
  end

  assign Led_o            = led_q;
  assign Alarma_o         = (state_q == ALARMA);
  assign Activos_o        = c;
  assign variableestado_o = seg7({2'b00, state_q});
  assign variablealerta_o = seg7(4'(c));

endmodule

// File: tb/tb_maq_alarma_multicanal.sv
// Randomized bench for maq_alarma_multicanal against a behavioural model of
// the filter/FSM rules, plus directed scenarios with literal expectations.
module tb_maq_alarma_multicanal;
  localparam int NC  = 4;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sens = '0;
  logic       ack = 1'b0;
  logic [6:0] estado, alerta;
  logic [3:0] led;
  logic       alarma;
  logic [2:0] activos;

  int n_vec = 0;
  int n_err = 0;

  // model state: names of the states are just the codes 0..3
  int       m_run [NC];
  bit [3:0] m_filt, m_led;
  int       m_state;
  int       v_c;
  bit       v_r, v_ack;

  maq_alarma_multicanal #(.N_CH(NC), .DEB_CYC(DEB)) dut (
    .CLK_clk_i(clk), .RST_rst_n_i(rst_n), .Sensor_i(sens), .Ack_i(ack),
    .variableestado_o(estado), .variablealerta_o(alerta), .Led_o(led),
    .Alarma_o(alarma), .Activos_o(activos)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_run[i] = 0;
    m_filt = '0; m_led = '0; m_state = 0;
    v_c = 0; v_r = 1'b0; v_ack = 1'b0;
  endtask

  // One rising edge: filters see the live inputs, the FSM sees what the
  // filters/ack looked like one edge earlier.
  task automatic model_edge(input bit [3:0] s, input bit a);
    bit [3:0] nf;
    bit [3:0] rs;
    int ns;
    nf = m_filt;
    for (int i = 0; i < NC; i++) begin
      if (s[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          nf[i] = s[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    rs = nf & ~m_filt;
    for (int i = 0; i < NC; i++) begin
      if (rs[i]) m_led[i] = 1'b1;
      else if (a && !m_filt[i]) m_led[i] = 1'b0;
    end
    ns = m_state;
    case (m_state)
      0: ns = (v_c == 1) ? 1 : (v_c >= 2) ? 2 : 0;
      1: ns = (v_c == 0) ? 0 : (v_c >= 2) ? 2 : (v_ack && !v_r) ? 3 : 1;
      2: ns = (v_c == 0) ? 0 : (v_ack && !v_r) ? 3 : 2;
      default: ns = (v_c == 0) ? 0 : v_r ? 2 : 3;
    endcase
    m_state = ns;
    m_filt  = nf;
    v_c     = $countones(nf);
    v_r     = |rs;
    v_ack   = a;
  endtask

  task automatic check_all(input string tag);
    n_vec++;
    if (estado !== seg(m_state)) begin
      n_err++;
      $display("FAIL %s estado: got %b want %b", tag, estado, seg(m_state));
    end
    if (alerta !== seg($countones(m_filt))) begin
      n_err++;
      $display("FAIL %s alerta: got %b want %b", tag, alerta, seg($countones(m_filt)));
    end
    if (led !== m_led) begin
      n_err++;
      $display("FAIL %s led: got %b want %b", tag, led, m_led);
    end
    if (alarma !== (m_state == 2)) begin
      n_err++;
      $display("FAIL %s alarma: got %b want %b", tag, alarma, (m_state == 2));
    end
    if (activos !== 3'($countones(m_filt))) begin
      n_err++;
      $display("FAIL %s activos: got %0d want %0d", tag, activos, $countones(m_filt));
    end
  endtask

  task automatic lit(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic a);
    sens = s;
    ack  = a;
    @(posedge clk);
    model_edge(s, a);
    #1;
    check_all("cycle");
  endtask

  // Called at posedge+1: pulls reset between edges and releases before the next.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    lit("rst estado", estado, 7'b1000000);
    lit("rst alerta", alerta, 7'b1000000);
    lit("rst led", 7'(led), 7'd0);
    lit("rst alarma", 7'(alarma), 7'd0);
    lit("rst activos", 7'(activos), 7'd0);
    check_all("reset");
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rs;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    lit("por estado", estado, 7'b1000000);
    lit("por alerta", alerta, 7'b1000000);
    lit("por led", 7'(led), 7'd0);
    lit("por alarma", 7'(alarma), 7'd0);
    lit("por activos", 7'(activos), 7'd0);
    #2 rst_n = 1'b1;
    #1 check_all("release");

    // glitch shorter than the filter window
    repeat (3) step(4'b0001, 1'b0);
    repeat (2) step(4'b0000, 1'b0);
    lit("glitch activos", 7'(activos), 7'd0);
    lit("glitch estado", estado, 7'b1000000);
    lit("glitch led", 7'(led), 7'd0);

    // single channel alert
    repeat (6) step(4'b0010, 1'b0);
    lit("alert estado", estado, 7'b1111001);
    lit("alert alerta", alerta, 7'b1111001);
    lit("alert led", 7'(led), 7'b0000010);
    lit("alert alarma", 7'(alarma), 7'd0);

    // escalation
    repeat (5) step(4'b0110, 1'b0);
    lit("esc alarma", 7'(alarma), 7'd1);
    lit("esc estado", estado, 7'b0100100);
    lit("esc alerta", alerta, 7'b0100100);

    // acknowledge
    step(4'b0110, 1'b1);
    repeat (2) step(4'b0110, 1'b0);
    lit("ack estado", estado, 7'b0110000);
    lit("ack alarma", 7'(alarma), 7'd0);

    // new channel re-arms the alarm
    repeat (5) step(4'b1110, 1'b0);
    lit("rearm estado", estado, 7'b0100100);
    lit("rearm led", 7'(led), 7'b0001110);

    // ack on the same edge as a filter rise
    repeat (3) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    repeat (2) step(4'b1111, 1'b0);
    lit("coll alarma", 7'(alarma), 7'd1);
    lit("coll estado", estado, 7'b0100100);
    lit("coll led", 7'(led), 7'b0001111);

    // reset mid-alarm, sensors held high
    mid_reset();
    repeat (DEB) step(4'b1111, 1'b0);
    lit("rerun pre alarma", 7'(alarma), 7'd0);
    lit("rerun activos", 7'(activos), 7'd4);
    step(4'b1111, 1'b0);
    lit("rerun alarma", 7'(alarma), 7'd1);

    // randomized phase
    rs = 4'b1111;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 4) == 0) rs[$urandom_range(0, 3)] ^= 1'b1;
      step(rs, ($urandom_range(0, 7) == 0));
      if (k % 997 == 500) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
